// File: rtl/uart_loanio_bridge_pkg.sv
// Shared types and constants for the UART loan-IO bridge: owner encoding,
// bridge FSM states and the UART idle (mark) level.
package uart_bridge_pkg;

  typedef enum logic {
    OWNER_HPS = 1'b0,
    OWNER_MCU = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ST_HPS   = 2'd0,
    ST_MCU   = 2'd1,
    ST_DRAIN = 2'd2
  } bridge_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Steady state that corresponds to a given owner.
  function automatic bridge_state_e owner_state(input owner_e o);
    return (o == OWNER_MCU) ? ST_MCU : ST_HPS;
  endfunction

endpackage

// File: rtl/uart_loanio_bridge_if.sv
// Signal bundle between the bridge, the two UART endpoints and the loan-IO
// pads. The bridge uses the "bridge" modport; the surrounding system (or a
// bench) uses "env".
interface uart_loanio_if;

  logic owner_req;
  logic mcu_uart_tx;
  logic mcu_uart_rx;
  logic hps_uart_txd;
  logic hps_uart_rxd;
  logic loan_io_in_rx;
  logic loan_io_out_tx;
  logic loan_io_oe_tx;
  logic loan_io_oe_rx;
  logic owner;
  logic switching;

  modport bridge (
    input  owner_req, mcu_uart_tx, hps_uart_txd, loan_io_in_rx,
    output mcu_uart_rx, hps_uart_rxd, loan_io_out_tx, loan_io_oe_tx,
           loan_io_oe_rx, owner, switching
  );

  modport env (
    output owner_req, mcu_uart_tx, hps_uart_txd, loan_io_in_rx,
    input  mcu_uart_rx, hps_uart_rxd, loan_io_out_tx, loan_io_oe_tx,
           loan_io_oe_rx, owner, switching
  );

endinterface

// File: rtl/uart_loanio_bridge_rx_filter.sv
// RX pad conditioning: SYNC_STAGES-flop synchroniser followed by an agreement
// filter that only moves the output level once FILTER_LEN consecutive
// synchronised samples agree.
module uart_rx_filter
  import uart_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_rx_pin,
  output logic o_rx_level
);

  // The synchroniser and the sample history share one shift register: the
  // low SYNC_STAGES bits are the synchroniser, and the window of FILTER_LEN
  // bits starting at the last synchroniser flop holds the newest samples.
  localparam int CHAIN_LEN = SYNC_STAGES + FILTER_LEN - 1;

  logic [CHAIN_LEN-1:0]  r_chain;
  logic [FILTER_LEN-1:0] w_window;
  logic                  r_level;

  assign w_window   = r_chain[CHAIN_LEN-1 -: FILTER_LEN];
  assign o_rx_level = r_level;

  // Shift the pad level through the synchroniser and sample history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= {CHAIN_LEN{UART_IDLE_LEVEL}};
    end else begin
      r_chain <= {r_chain[CHAIN_LEN-2:0], i_rx_pin};
    end
  end

  // Move the filtered level only when the whole window agrees.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= UART_IDLE_LEVEL;
    end else if (&w_window) begin
      r_level <= 1'b1;
    end else if (~|w_window) begin
      r_level <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_loanio_bridge.sv
// Routes the loan-IO UART pin pair to either HPS UART0 or the MCU UART.
// Ownership changes are deferred until the line has been idle for
// IDLE_CYCLES consecutive cycles so no character is cut mid-frame.
module uart_loanio_bridge
  import uart_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int IDLE_CYCLES = 8680,
  parameter bit OWNER_RESET = 1'b0
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_loanio_if.bridge  bus
);

  localparam int               CNT_W      = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam owner_e           OWNER_INIT = owner_e'(OWNER_RESET);

  logic [1:0]       r_req_sync;
  owner_e           w_req;
  bridge_state_e    r_state;
  owner_e           r_owner;
  logic             r_switching;
  logic [CNT_W-1:0] r_idle_cnt;
  logic             w_rx_level;
  logic             w_owner_tx;
  logic             w_idle;
  logic             r_out_tx;
  logic             r_oe_tx;
  logic             r_oe_rx;
  logic             r_mcu_rx;
  logic             r_hps_rx;

  uart_rx_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_rx_filter (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_rx_pin   (bus.loan_io_in_rx),
    .o_rx_level (w_rx_level)
  );

  assign w_req      = owner_e'(r_req_sync[1]);
  assign w_owner_tx = (r_owner == OWNER_MCU) ? bus.mcu_uart_tx : bus.hps_uart_txd;
  assign w_idle     = (w_owner_tx == UART_IDLE_LEVEL) && (w_rx_level == UART_IDLE_LEVEL);

  // Bring the asynchronous owner request into the clock domain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_req_sync <= {2{OWNER_RESET}};
    end else begin
      r_req_sync <= {r_req_sync[0], bus.owner_req};
    end
  end

  // Ownership FSM: wait for a long idle gap before handing the line over.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= owner_state(OWNER_INIT);
      r_owner     <= OWNER_INIT;
      r_switching <= 1'b0;
      r_idle_cnt  <= '0;
    end else begin
      unique case (r_state)
        ST_HPS, ST_MCU: begin
          r_idle_cnt <= '0;
          if (w_req != r_owner) begin
            r_state     <= ST_DRAIN;
            r_switching <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_req == r_owner) begin
            // Request withdrawn: stay with the current owner.
            r_state     <= owner_state(r_owner);
            r_switching <= 1'b0;
            r_idle_cnt  <= '0;
          end else if (!w_idle) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == CNT_LAST) begin
            r_owner     <= w_req;
            r_state     <= owner_state(w_req);
            r_switching <= 1'b0;
            r_idle_cnt  <= '0;
          end else if (r_idle_cnt != CNT_MAX) begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= owner_state(r_owner);
          r_switching <= 1'b0;
          r_idle_cnt  <= '0;
        end
      endcase
    end
  end

  // Registered pad and endpoint outputs, routed by the current owner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_tx <= UART_IDLE_LEVEL;
      r_oe_tx  <= 1'b0;
      r_oe_rx  <= 1'b0;
      r_mcu_rx <= UART_IDLE_LEVEL;
      r_hps_rx <= UART_IDLE_LEVEL;
    end else begin
      r_out_tx <= w_owner_tx;
      r_oe_tx  <= 1'b1;
      r_oe_rx  <= 1'b0;
      r_hps_rx <= (r_owner == OWNER_HPS) ? w_rx_level : UART_IDLE_LEVEL;
      r_mcu_rx <= (r_owner == OWNER_MCU) ? w_rx_level : UART_IDLE_LEVEL;
    end
  end

  assign bus.loan_io_out_tx = r_out_tx;
  assign bus.loan_io_oe_tx  = r_oe_tx;
  assign bus.loan_io_oe_rx  = r_oe_rx;
  assign bus.mcu_uart_rx    = r_mcu_rx;
  assign bus.hps_uart_rxd   = r_hps_rx;
  assign bus.owner          = r_owner;
  assign bus.switching      = r_switching;

endmodule

// File: tb/tb_uart_loanio_bridge.sv
// Directed bench for uart_loanio_bridge with IDLE_CYCLES = 16 and HPS as the
// reset owner: reset values, TX/RX routing, glitch filtering, clean and
// deferred ownership switches, and aborted switches.
module tb_uart_loanio_bridge;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  uart_loanio_if bus ();

  uart_loanio_bridge #(
    .SYNC_STAGES (2),
    .FILTER_LEN  (3),
    .IDLE_CYCLES (16),
    .OWNER_RESET (1'b0)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic  hps_tx;
    logic  mcu_tx;
    logic  exp_tx;
    string name;
  } tx_vec_t;

  tx_vec_t tx_tab [6];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step 1 time unit off the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    int mcu_lows;
    int first_low;
    int n;

    tx_tab[0] = '{1'b1, 1'b1, 1'b1, "tx idle"};
    tx_tab[1] = '{1'b0, 1'b1, 1'b0, "hps tx low"};
    tx_tab[2] = '{1'b1, 1'b1, 1'b1, "hps tx high"};
    tx_tab[3] = '{1'b1, 1'b0, 1'b1, "mcu tx ignored"};
    tx_tab[4] = '{1'b0, 1'b0, 1'b0, "both tx low"};
    tx_tab[5] = '{1'b1, 1'b1, 1'b1, "tx restored"};

    bus.owner_req     = 1'b0;
    bus.mcu_uart_tx   = 1'b1;
    bus.hps_uart_txd  = 1'b1;
    bus.loan_io_in_rx = 1'b1;
    reset_n           = 1'b0;

    // Reset values
    tick(3);
    chk("rst out_tx",    bus.loan_io_out_tx, 1'b1);
    chk("rst oe_tx",     bus.loan_io_oe_tx,  1'b0);
    chk("rst oe_rx",     bus.loan_io_oe_rx,  1'b0);
    chk("rst hps_rxd",   bus.hps_uart_rxd,   1'b1);
    chk("rst mcu_rx",    bus.mcu_uart_rx,    1'b1);
    chk("rst owner",     bus.owner,          1'b0);
    chk("rst switching", bus.switching,      1'b0);
    reset_n = 1'b1;
    #1;
    chk("oe_tx before first edge", bus.loan_io_oe_tx, 1'b0);
    tick(1);
    chk("oe_tx after release", bus.loan_io_oe_tx, 1'b1);
    chk("oe_rx after release", bus.loan_io_oe_rx, 1'b0);

    // TX pass-through table, owner HPS
    for (int i = 0; i < 6; i++) begin
      bus.hps_uart_txd = tx_tab[i].hps_tx;
      bus.mcu_uart_tx  = tx_tab[i].mcu_tx;
      tick(1);
      chk(tx_tab[i].name, bus.loan_io_out_tx, tx_tab[i].exp_tx);
    end

    // RX latency: pad sampled at the first edge, output 5 edges later
    bus.loan_io_in_rx = 1'b0;
    tick(5);
    chk("rx fall not early", bus.hps_uart_rxd, 1'b1);
    tick(1);
    chk("rx fall latency", bus.hps_uart_rxd, 1'b0);
    chk("mcu rx held idle", bus.mcu_uart_rx, 1'b1);
    bus.loan_io_in_rx = 1'b1;
    tick(5);
    chk("rx rise not early", bus.hps_uart_rxd, 1'b0);
    tick(1);
    chk("rx rise latency", bus.hps_uart_rxd, 1'b1);

    // Glitch of 2 samples is rejected
    bus.loan_io_in_rx = 1'b0;
    tick(2);
    bus.loan_io_in_rx = 1'b1;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.hps_uart_rxd !== 1'b1 || bus.mcu_uart_rx !== 1'b1) lows++;
    end
    chkint("glitch2 low cycles", lows, 0);

    // Pulse of 3 samples passes as a 3-cycle low on the owner RX only
    bus.loan_io_in_rx = 1'b0;
    tick(3);
    bus.loan_io_in_rx = 1'b1;
    lows = 0;
    mcu_lows = 0;
    first_low = -1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.hps_uart_rxd === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = i;
      end
      if (bus.mcu_uart_rx !== 1'b1) mcu_lows++;
    end
    chkint("pulse3 low cycles", lows, 3);
    chkint("pulse3 first low", first_low, 2);
    chkint("pulse3 mcu untouched", mcu_lows, 0);

    // Clean switch to MCU
    bus.owner_req = 1'b1;
    tick(2);
    chk("switching not early", bus.switching, 1'b0);
    tick(1);
    chk("switching after 3", bus.switching, 1'b1);
    chk("owner during drain", bus.owner, 1'b0);
    tick(15);
    chk("owner before flip", bus.owner, 1'b0);
    chk("switching before flip", bus.switching, 1'b1);
    tick(1);
    chk("owner flipped", bus.owner, 1'b1);
    chk("switching fell", bus.switching, 1'b0);
    bus.mcu_uart_tx = 1'b0;
    tick(1);
    chk("mcu tx to pad", bus.loan_io_out_tx, 1'b0);
    bus.mcu_uart_tx  = 1'b1;
    bus.hps_uart_txd = 1'b0;
    tick(1);
    chk("hps tx ignored", bus.loan_io_out_tx, 1'b1);
    bus.hps_uart_txd = 1'b1;
    bus.loan_io_in_rx = 1'b0;
    tick(6);
    chk("mcu rx routed", bus.mcu_uart_rx, 1'b0);
    chk("hps rx parked", bus.hps_uart_rxd, 1'b1);
    bus.loan_io_in_rx = 1'b1;
    tick(6);
    chk("mcu rx back idle", bus.mcu_uart_rx, 1'b1);

    // Switch back to HPS with a bounded wait
    bus.owner_req = 1'b0;
    n = 0;
    while (bus.owner !== 1'b0 && n < 40) begin
      tick(1);
      n++;
    end
    chkint("switch back cycles", n, 19);

    // Deferred switch: HPS keeps talking
    bus.owner_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.hps_uart_txd = i[0];
      tick(10);
      chk("deferred owner held", bus.owner, 1'b0);
      chk("deferred tx routed", bus.loan_io_out_tx, i[0]);
    end
    chk("deferred switching", bus.switching, 1'b1);
    bus.hps_uart_txd = 1'b1;
    tick(15);
    chk("deferred before flip", bus.owner, 1'b0);
    tick(1);
    chk("deferred flipped", bus.owner, 1'b1);
    chk("deferred switching fell", bus.switching, 1'b0);

    // Abort by withdrawing the request
    bus.owner_req = 1'b0;
    tick(3);
    chk("abort switching up", bus.switching, 1'b1);
    tick(8);
    bus.owner_req = 1'b1;
    tick(2);
    chk("abort switching held", bus.switching, 1'b1);
    tick(1);
    chk("abort switching fell", bus.switching, 1'b0);
    chk("abort owner kept", bus.owner, 1'b1);
    tick(20);
    chk("abort owner stable", bus.owner, 1'b1);
    chk("abort no drain", bus.switching, 1'b0);

    // Reset asserted mid-drain
    bus.owner_req = 1'b0;
    tick(3);
    chk("pre-reset switching", bus.switching, 1'b1);
    bus.mcu_uart_tx = 1'b0;
    tick(5);
    chk("pre-reset out_tx", bus.loan_io_out_tx, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid reset owner",     bus.owner,          1'b0);
    chk("mid reset switching", bus.switching,      1'b0);
    chk("mid reset oe_tx",     bus.loan_io_oe_tx,  1'b0);
    chk("mid reset out_tx",    bus.loan_io_out_tx, 1'b1);
    chk("mid reset mcu_rx",    bus.mcu_uart_rx,    1'b1);
    chk("mid reset hps_rxd",   bus.hps_uart_rxd,   1'b1);
    tick(2);
    bus.mcu_uart_tx = 1'b1;
    reset_n = 1'b1;
    tick(2);
    chk("post reset owner", bus.owner, 1'b0);
    chk("post reset switching", bus.switching, 1'b0);
    chk("post reset oe_tx", bus.loan_io_oe_tx, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_loanio_bridge.md
# uart_loanio_bridge

Bridges the single UART pin pair on the HPS loan-IO lines (LOANIO49 = RX into FPGA, LOANIO50 = TX out of FPGA) to one of two UART owners: the HPS UART0 or the RISC-V MCU UART. It sits between the `mcu_qsys` loan-IO ports and both UART endpoints. It resynchronises and deglitches the incoming RX line and registers the outgoing TX line. Ownership changes only after the line has been idle long enough that no character is cut mid-frame.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flops in the RX synchroniser; must be ≥ 2.
- `FILTER_LEN`, 3: consecutive identical synchronised samples required before the filtered RX level changes; must be ≥ 1.
- `IDLE_CYCLES`, 8680: consecutive idle cycles required before ownership switches (two 10-bit characters at 115200 baud from a 50 MHz clock).
- `OWNER_RESET`, 0: owner after reset; 0 = HPS, 1 = MCU.

Ports:
- `clock` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `owner_req` in 1: requested owner (0 HPS, 1 MCU); asynchronous, so it is synchronised internally.
- `mcu_uart_tx` in 1: TX from the MCU UART.
- `mcu_uart_rx` out 1: RX to the MCU UART.
- `hps_uart_txd` in 1: TX from HPS UART0.
- `hps_uart_rxd` out 1: RX to HPS UART0.
- `loan_io_in_rx` in 1: level sampled from the LOANIO49 pad.
- `loan_io_out_tx` out 1: output value for the LOANIO50 pad.
- `loan_io_oe_tx` out 1: output enable for LOANIO50.
- `loan_io_oe_rx` out 1: output enable for LOANIO49; constant 0 after reset.
- `owner` out 1: current owner.
- `switching` out 1: high while an ownership change is pending.

## Operation
- All outputs are registered. Reset values:
  - `loan_io_out_tx` = 1, `loan_io_oe_tx` = 0, `loan_io_oe_rx` = 0.
  - `mcu_uart_rx` = 1, `hps_uart_rxd` = 1.
  - `owner` = `OWNER_RESET`, `switching` = 0.
  - The filtered RX level resets to 1, the idle counter to 0, and every synchroniser stage to 1.
- `loan_io_oe_tx` rises one cycle after reset deassertion and then stays 1.
- `owner_req` passes through its own 2-flop synchroniser, reset value `OWNER_RESET`.
- TX path: `loan_io_out_tx` is the registered TX of the current owner. The non-owner's TX is ignored.
- RX path:
  - The pin goes through the `SYNC_STAGES` synchroniser.
  - The filtered level changes only when the last `FILTER_LEN` synchronised samples are all equal and differ from the current level.
  - The filtered level drives the owner's RX output; the non-owner's RX output is held at 1 (idle).
- State machine, states `ST_HPS`, `ST_MCU`, `ST_DRAIN`:
  - `ST_HPS` / `ST_MCU` → `ST_DRAIN` when the synchronised request differs from `owner`. The idle counter is cleared.
  - In `ST_DRAIN` the old owner keeps both TX and RX, and `switching` = 1.
  - A cycle counts as idle when both the owner's TX and the filtered RX are 1. Any non-idle cycle clears the counter to 0.
  - When the counter reaches `IDLE_CYCLES - 1` on an idle cycle, `owner` flips and the FSM enters the new owner's state; `switching` falls in the same cycle.
  - If the request reverts to `owner` during `ST_DRAIN`, the FSM returns to the owner's state with no flip and the counter is cleared.
- Counter width is `$clog2(IDLE_CYCLES+1)`; the counter saturates and never wraps.
- Asserting reset mid-drain aborts the switch; `owner` returns to `OWNER_RESET`.

## Timing
- TX latency is 1 cycle: a change on the owner's TX appears on `loan_io_out_tx` on the next edge.
- RX latency is `SYNC_STAGES + FILTER_LEN` cycles from the first pad sample to the RX output, which is 5 with the defaults. A pad level held for fewer than `FILTER_LEN` synchronised cycles never reaches any RX output.
- `owner_req` to `switching` high: 3 cycles (2 synchroniser flops plus 1 for the FSM register).
- Switch completion: `owner` flips exactly `IDLE_CYCLES` cycles after the first cycle of an uninterrupted idle run inside `ST_DRAIN`.
- On the cycle after the flip, routing changes:
  - `loan_io_out_tx` takes the new owner's TX.
  - The old owner's RX output goes to 1.
  - The new owner's RX output takes the filtered level.

## Structure
- Package `uart_bridge_pkg`:
  - `owner_e` with `OWNER_HPS` = 0 and `OWNER_MCU` = 1.
  - `bridge_state_e` with `ST_HPS`, `ST_MCU`, `ST_DRAIN`.
  - Constant `UART_IDLE_LEVEL` = 1'b1.
- Sub-module `uart_rx_filter`: parameterised by `SYNC_STAGES` and `FILTER_LEN`; contains the synchroniser and the agreement filter; outputs the filtered level.
- The FSM, idle counter and routing live in `uart_loanio_bridge`.

## Test plan
Benches use `IDLE_CYCLES` = 16 and `OWNER_RESET` = 0.
- Reset check: during reset, `loan_io_out_tx` = 1, `loan_io_oe_tx` = 0, both RX outputs = 1, `owner` = 0. After release, `loan_io_oe_tx` = 1 one cycle later.
- TX/RX pass-through: `hps_uart_txd` driven 0 → `loan_io_out_tx` = 0 one cycle later. Pad driven 0 → `hps_uart_rxd` = 0 after 5 cycles; `mcu_uart_rx` stays 1.
- Glitch rejection: pad held low for 2 cycles → no RX output changes. Pad held low for 3 cycles → owner RX pulses low.
- Clean switch: `owner_req` = 1 with both lines idle → `switching` high after 3 cycles, `owner` = 1 after 16 more cycles. `mcu_uart_tx` = 0 then reaches the pad.
- Deferred switch: HPS TX toggles every 10 cycles while `owner_req` = 1 → `owner` stays 0. Toggling stops → `owner` flips after 16 idle cycles.
- Aborts: `owner_req` returns to 0 after 8 drain cycles → `switching` falls and `owner` stays 0. Reset asserted mid-drain → outputs return to reset values immediately.
